// File: rtl/nrf_spi_if.sv
// nrf_spi_if: host-side streaming handshake between the radio sequencer and nrf_spi_master
// Signals: start/ch_sel/len request a transaction; tx_data/tx_ready stream bytes out;
// rx_data/rx_valid stream bytes in; busy/done/err report transaction status.
// Modports: master = sequencer side, slave = SPI engine side.
interface nrf_spi_if #(
    parameter int CH_W  = 1,
    parameter int LEN_W = 6
);
    logic             start;
    logic [CH_W-1:0]  ch_sel;
    logic [LEN_W-1:0] len;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;
    logic             err;
    modport master (
        output start, ch_sel, len, tx_data,
        input  tx_ready, rx_data, rx_valid, busy, done, err
    );
    modport slave (
        input  start, ch_sel, len, tx_data,
        output tx_ready, rx_data, rx_valid, busy, done, err
    );
endinterface

// File: rtl/nrf_spi_master.sv
// nrf_spi_master: one SPI mode-0 master engine shared by NUM_CH nRF24L01 radios
// Ports: clk_10/rst (sync, active high); host = nrf_spi_if.slave streaming handshake;
// ce_in -> ce (registered one cycle); csn per radio (active low); sck/mosi shared;
// miso per radio, muxed by the latched channel.
// Optional NRF_SPI_STATUS_CAPTURE_EN adds status[7:0]/status_valid, capturing the
// first received byte (nRF24 STATUS) of every transaction.
module nrf_spi_master #(
    parameter int NUM_CH  = 2,
    parameter int CH_W    = 1,
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 33,
    parameter int LEN_W   = 6
) (
    input  logic              clk_10,
    input  logic              rst,
    nrf_spi_if.slave          host,
    input  logic [NUM_CH-1:0] ce_in,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] csn,
    output logic              sck,
    output logic              mosi,
    input  logic [NUM_CH-1:0] miso
`ifdef NRF_SPI_STATUS_CAPTURE_EN
    ,
    output logic [7:0]        status,
    output logic              status_valid
`endif
);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, NEXT, HOLD, DONE} state_t;
    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic              phase_q, phase_d;
    logic              bit_in_q, bit_in_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              err_q, err_d;
    logic [7:0]        sr_q, sr_d;
    logic [7:0]        rx_q, rx_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [NUM_CH-1:0] csn_q, csn_d;
    logic [NUM_CH-1:0] ce_q;
    logic              div_end, load, bad_req, miso_sel;
`ifdef NRF_SPI_STATUS_CAPTURE_EN
    logic [7:0]        status_q, status_d;
    logic              first_q, first_d;
`endif
    assign div_end  = div_q == DIV_LAST;
    // NEXT doubles as LOAD when more bytes remain, so bytes stream back to back
    assign load     = state_q == LOAD || (state_q == NEXT && rem_q != LEN_W'(1));
    assign bad_req  = host.len == '0 || int'(host.len) > MAX_LEN || int'(host.ch_sel) >= NUM_CH;
    assign miso_sel = |(miso & (NUM_CH'(1) << ch_q));
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        phase_d  = phase_q;
        bit_in_d = bit_in_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        err_d    = 1'b0;
        sr_d     = sr_q;
        rx_d     = rx_q;
        ch_d     = ch_q;
        rem_d    = rem_q;
        csn_d    = csn_q;
`ifdef NRF_SPI_STATUS_CAPTURE_EN
        status_d = status_q;
        first_d  = first_q;
`endif
        case (state_q)
            IDLE: begin
                if (host.start && bad_req) begin
                    err_d = 1'b1;
                end else if (host.start) begin
                    ch_d    = host.ch_sel;
                    rem_d   = host.len;
                    csn_d   = ~(NUM_CH'(1) << host.ch_sel);
                    div_d   = '0;
                    state_d = SETUP;
`ifdef NRF_SPI_STATUS_CAPTURE_EN
                    first_d = 1'b1;
`endif
                end
            end
            SETUP: begin
                div_d   = div_end ? '0 : div_q + 1'b1;
                state_d = div_end ? LOAD : SETUP;
            end
            LOAD: ;
            SHIFT: begin
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end) begin
                    phase_d = ~phase_q;
                    sck_d   = ~phase_q;
                    // miso is captured on the rising edge but shifted in on the falling edge
                    if (!phase_q) begin
                        bit_in_d = miso_sel;
                    end else begin
                        sr_d  = {sr_q[6:0], bit_in_q};
                        bit_d = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            rx_d    = {sr_q[6:0], bit_in_q};
                            state_d = NEXT;
`ifdef NRF_SPI_STATUS_CAPTURE_EN
                            status_d = first_q ? {sr_q[6:0], bit_in_q} : status_q;
`endif
                        end else begin
                            mosi_d = sr_q[6];
                        end
                    end
                end
            end
            NEXT: begin
                rem_d   = rem_q - 1'b1;
                div_d   = '0;
                state_d = HOLD;
`ifdef NRF_SPI_STATUS_CAPTURE_EN
                first_d = 1'b0;
`endif
            end
            HOLD: begin
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end) begin
                    csn_d   = '1;
                    mosi_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            sr_d    = host.tx_data;
            mosi_d  = host.tx_data[7];
            div_d   = '0;
            phase_d = 1'b0;
            bit_d   = '0;
            state_d = SHIFT;
        end
    end
    always_ff @(posedge clk_10) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            bit_in_q <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            err_q    <= 1'b0;
            sr_q     <= '0;
            rx_q     <= '0;
            ch_q     <= '0;
            rem_q    <= '0;
            csn_q    <= '1;
            ce_q     <= '0;
`ifdef NRF_SPI_STATUS_CAPTURE_EN
            status_q <= '0;
            first_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            bit_in_q <= bit_in_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            err_q    <= err_d;
            sr_q     <= sr_d;
            rx_q     <= rx_d;
            ch_q     <= ch_d;
            rem_q    <= rem_d;
            csn_q    <= csn_d;
            ce_q     <= ce_in;
`ifdef NRF_SPI_STATUS_CAPTURE_EN
            status_q <= status_d;
            first_q  <= first_d;
`endif
        end
    end
    assign host.tx_ready = load;
    assign host.rx_valid = state_q == NEXT;
    assign host.rx_data  = rx_q;
    assign host.busy     = state_q != IDLE && state_q != DONE;
    assign host.done     = state_q == DONE || err_q;
    assign host.err      = err_q;
    assign ce            = ce_q;
    assign csn           = csn_q;
    assign sck           = sck_q;
    assign mosi          = mosi_q;
`ifdef NRF_SPI_STATUS_CAPTURE_EN
    assign status        = status_q;
    assign status_valid  = state_q == NEXT && first_q;
`endif
endmodule

// File: tb/tb_nrf_spi_master.sv
// tb_nrf_spi_master: directed self-checking bench for nrf_spi_master
module tb_nrf_spi_master;
    localparam int NUM_CH = 2, CH_W = 2, CLK_DIV = 2, MAX_LEN = 33, LEN_W = 6;
    logic clk_10 = 1'b0;
    logic rst = 1'b1;
    always #5 clk_10 = ~clk_10;
    nrf_spi_if #(.CH_W(CH_W), .LEN_W(LEN_W)) bus ();
    logic [NUM_CH-1:0] ce_in, ce, csn, miso;
    logic sck, mosi;
`ifdef NRF_SPI_STATUS_CAPTURE_EN
    logic [7:0] status;
    logic status_valid;
`endif
    nrf_spi_master #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk_10(clk_10), .rst(rst), .host(bus), .ce_in(ce_in), .ce(ce), .csn(csn),
        .sck(sck), .mosi(mosi), .miso(miso)
`ifdef NRF_SPI_STATUS_CAPTURE_EN
        , .status(status), .status_valid(status_valid)
`endif
    );
    int vectors = 0, miscompares = 0;
    int cyc = 0, n_txr = 0, n_rxv = 0, n_done = 0, n_err = 0, n_both = 0, sck_n = 0, tx_idx = 0, mi_base = 0;
    int csn_low [NUM_CH];
    int txr_cyc [0:127];
    logic [7:0] rx_log [0:127];
    logic [7:0] st_log [0:127];
    logic sv_log [0:127];
    logic mo_bits [0:2047];
    logic [7:0] mi_bytes [0:63];
    logic [7:0] tx_bytes [0:127];
    logic txr_prev = 1'b0;
    logic mch = 1'b0;
    logic [5:0] mi_idx;
    logic [2:0] mi_bit;
    logic mb;
    // Radio model: selected radio shifts mi_bytes out MSB first, the other drives the complement
    always_comb begin
        mi_idx = 6'((sck_n - mi_base) / 8);
        mi_bit = 3'(7 - ((sck_n - mi_base) % 8));
    end
    assign mb = mi_bytes[mi_idx][mi_bit];
    assign miso = mch ? {mb, ~mb} : {~mb, mb};
    assign bus.tx_data = tx_bytes[tx_idx[6:0]];
    initial for (int i = 0; i < NUM_CH; i++) csn_low[i] = 0;
    always @(negedge clk_10) begin
        cyc <= cyc + 1;
        if (bus.tx_ready) begin
            txr_cyc[n_txr[6:0]] <= cyc;
            n_txr <= n_txr + 1;
        end
        if (txr_prev) tx_idx <= tx_idx + 1;
        txr_prev <= bus.tx_ready;
        if (bus.rx_valid) begin
            rx_log[n_rxv[6:0]] <= bus.rx_data;
`ifdef NRF_SPI_STATUS_CAPTURE_EN
            st_log[n_rxv[6:0]] <= status;
            sv_log[n_rxv[6:0]] <= status_valid;
`endif
            n_rxv <= n_rxv + 1;
        end
        if (bus.done) n_done <= n_done + 1;
        if (bus.err) n_err <= n_err + 1;
        for (int i = 0; i < NUM_CH; i++) if (!csn[i]) csn_low[i] <= csn_low[i] + 1;
        if (csn == '0) n_both <= n_both + 1;
    end
    always @(posedge sck) begin
        mo_bits[sck_n[10:0]] <= mosi;
        sck_n <= sck_n + 1;
    end
    task automatic tick();
        @(posedge clk_10);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic go(input logic [CH_W-1:0] ch, input logic [LEN_W-1:0] n);
        bus.ch_sel = ch;
        bus.len = n;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic wait_done(input int max);
        int k = 0;
        while (!bus.done && k < max) begin
            tick();
            k++;
        end
        chk("done_reached", 32'(bus.done), 1);
        tick();
    endtask
    function automatic logic [7:0] mo_byte(input int base);
        logic [7:0] b = '0;
        for (int j = 0; j < 8; j++) b = {b[6:0], mo_bits[(base + j) % 2048]};
        return b;
    endfunction
    int b_txr, b_rxv, b_done, b_err, b_c0, b_c1, b_sck, bad;
    logic [1:0] rc [4] = '{2'd0, 2'd0, 2'd0, 2'd2};
    logic [5:0] rl [4] = '{6'd0, 6'd40, 6'd34, 6'd1};
    task automatic snap();
        b_txr = n_txr; b_rxv = n_rxv; b_done = n_done; b_err = n_err;
        b_c0 = csn_low[0]; b_c1 = csn_low[1]; b_sck = sck_n;
        mi_base = sck_n;
    endtask
    initial begin
        bus.start = 1'b0; bus.ch_sel = '0; bus.len = '0; ce_in = '0;
        repeat (3) tick();
        chk("rst_csn", 32'(csn), 32'h3);
        chk("rst_sck", 32'(sck), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_ce", 32'(ce), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_txr", 32'(bus.tx_ready), 0);
        chk("rst_rxv", 32'(bus.rx_valid), 0);
        chk("rst_rxd", 32'(bus.rx_data), 0);
`ifdef NRF_SPI_STATUS_CAPTURE_EN
        chk("rst_status", 32'(status), 0);
`endif
        rst = 1'b0;
        ce_in = 2'b10;
        tick();
        ce_in = 2'b01;
        chk("ce_reg_a", 32'(ce), 32'h2);
        tick();
        chk("ce_reg_b", 32'(ce), 32'h1);
        // single byte on radio 0
        snap();
        mch = 1'b0; mi_bytes[0] = 8'h3C; tx_bytes[tx_idx[6:0]] = 8'hA5;
        go(0, 1);
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_csn", 32'(csn), 32'h2);
        wait_done(200);
        chk("t1_csn0_low", 32'(csn_low[0] - b_c0), 38);
        chk("t1_csn1_low", 32'(csn_low[1] - b_c1), 0);
        chk("t1_mosi", 32'(mo_byte(b_sck)), 32'hA5);
        chk("t1_nrx", 32'(n_rxv - b_rxv), 1);
        chk("t1_rxd", 32'(rx_log[b_rxv[6:0]]), 32'h3C);
        chk("t1_ndone", 32'(n_done - b_done), 1);
        chk("t1_csn_end", 32'(csn), 32'h3);
        // full 33-byte transaction on radio 1
        snap();
        mch = 1'b1;
        for (int k = 0; k < 33; k++) begin
            tx_bytes[(tx_idx + k) % 128] = k == 0 ? 8'h20 : 8'(k - 1);
            mi_bytes[k] = 8'(8'h40 + 3 * k);
        end
        go(1, 33);
        repeat (100) tick();
        chk("t2_busy_mid", 32'(bus.busy), 1);
        wait_done(2000);
        chk("t2_ntxr", 32'(n_txr - b_txr), 33);
        bad = 0;
        for (int k = 1; k < 33; k++) if (txr_cyc[(b_txr + k) % 128] - txr_cyc[(b_txr + k - 1) % 128] != 33) bad++;
        chk("t2_txr_spacing", 32'(bad), 0);
        chk("t2_nrx", 32'(n_rxv - b_rxv), 33);
        chk("t2_sck", 32'(sck_n - b_sck), 264);
        chk("t2_csn1_low", 32'(csn_low[1] - b_c1), 1094);
        chk("t2_csn0_low", 32'(csn_low[0] - b_c0), 0);
        bad = 0;
        for (int k = 0; k < 33; k++) begin
            if (rx_log[(b_rxv + k) % 128] !== 8'(8'h40 + 3 * k)) bad++;
            if (mo_byte(b_sck + 8 * k) !== (k == 0 ? 8'h20 : 8'(k - 1))) bad++;
        end
        chk("t2_data", 32'(bad), 0);
        // rejected requests
        snap();
        for (int i = 0; i < 4; i++) begin
            go(rc[i], rl[i]);
            chk("t3_done", 32'(bus.done), 1);
            chk("t3_err", 32'(bus.err), 1);
            chk("t3_busy", 32'(bus.busy), 0);
            chk("t3_csn", 32'(csn), 32'h3);
            tick();
            chk("t3_done_end", 32'(bus.done), 0);
        end
        chk("t3_ntxr", 32'(n_txr - b_txr), 0);
        chk("t3_nerr", 32'(n_err - b_err), 4);
        // start while busy is ignored
        snap();
        mch = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tx_bytes[(tx_idx + k) % 128] = 8'(8'h11 * (k + 1));
            mi_bytes[k] = 8'(8'hAA + 8'h11 * k);
        end
        go(0, 3);
        for (int k = 0; k < 500 && n_txr < b_txr + 2; k++) tick();
        repeat (16) tick();
        go(1, 1);
        chk("t4_csn_mid", 32'(csn), 32'h2);
        wait_done(500);
        chk("t4_ntxr", 32'(n_txr - b_txr), 3);
        chk("t4_nrx", 32'(n_rxv - b_rxv), 3);
        chk("t4_rxd2", 32'(rx_log[(b_rxv + 2) % 128]), 32'hCC);
        repeat (10) tick();
        chk("t4_ndone", 32'(n_done - b_done), 1);
        chk("t4_idle", 32'(bus.busy), 0);
        chk("t4_csn_end", 32'(csn), 32'h3);
        // reset during the first byte
        snap();
        tx_bytes[tx_idx[6:0]] = 8'hF0; mi_bytes[0] = 8'h81;
        go(0, 2);
        repeat (10) tick();
        chk("t5_sck_started", 32'(sck_n > b_sck), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_csn", 32'(csn), 32'h3);
        chk("t5_sck", 32'(sck), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_done", 32'(bus.done), 0);
        repeat (5) tick();
        chk("t5_no_done", 32'(n_done - b_done), 0);
        snap();
        mch = 1'b1; mi_bytes[0] = 8'h96; tx_bytes[tx_idx[6:0]] = 8'h5A;
        go(1, 1);
        wait_done(200);
        chk("t5_rxd", 32'(rx_log[b_rxv[6:0]]), 32'h96);
        chk("t5_mosi", 32'(mo_byte(b_sck)), 32'h5A);
        chk("t5_ndone", 32'(n_done - b_done), 1);
        chk("t5_both_low", 32'(n_both), 0);
`ifdef NRF_SPI_STATUS_CAPTURE_EN
        snap();
        mch = 1'b0; mi_bytes[0] = 8'h0E; mi_bytes[1] = 8'h55;
        tx_bytes[tx_idx[6:0]] = 8'hFF; tx_bytes[(tx_idx + 1) % 128] = 8'h00;
        go(0, 2);
        wait_done(300);
        chk("t6_st0", 32'(st_log[b_rxv[6:0]]), 32'h0E);
        chk("t6_sv0", 32'(sv_log[b_rxv[6:0]]), 1);
        chk("t6_sv1", 32'(sv_log[(b_rxv + 1) % 128]), 0);
        chk("t6_rx1", 32'(rx_log[(b_rxv + 1) % 128]), 32'h55);
        chk("t6_hold", 32'(status), 32'h0E);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nrf_spi_master.md
Name: nrf_spi_master

Overview:
- Parametrised successor to the two-link nRF24L01 SPI controller.
- Drives NUM_CH nRF24L01 radios from one SPI master engine: shared SCK/MOSI, per-channel CSN/CE/MISO.
- Runs multi-byte transactions (command byte plus payload, up to MAX_LEN bytes) with a byte-streaming handshake to the top module.
- Sits between the top-level radio sequencer and the board pins, clocked by the 10 MHz divider output.

Parameters:
- NUM_CH, 2, number of attached radios (1..8).
- CH_W, 1, width of ch_sel; must satisfy 2**CH_W >= NUM_CH.
- CLK_DIV, 2, clk_10 cycles per SCK half-period (>=1). SCK = clk_10 / (2*CLK_DIV); default gives 2.5 MHz.
- MAX_LEN, 33, maximum bytes per transaction (1 command + 32 payload).
- LEN_W, 6, width of len; must satisfy 2**LEN_W > MAX_LEN.

Ports:
- clk_10  in  1  10 MHz clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle request; sampled only in IDLE.
- ch_sel  in  CH_W  target radio, sampled with start.
- len  in  LEN_W  byte count, sampled with start.
- tx_data  in  8  byte to send; sampled in the cycle tx_ready=1.
- tx_ready  out  1  1-cycle pulse: tx_data consumed, present the next byte.
- rx_data  out  8  byte received; valid while rx_valid=1.
- rx_valid  out  1  1-cycle pulse per received byte.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse at transaction end.
- err  out  1  1-cycle pulse, together with done, for a rejected request.
- ce_in  in  NUM_CH  chip-enable requests from the top module.
- ce  out  NUM_CH  ce_in registered by one cycle.
- csn  out  NUM_CH  active-low chip selects.
- sck  out  1  SPI clock, mode 0 (idle low).
- mosi  out  1  shared SPI data out.
- miso  in  NUM_CH  per-radio SPI data in; muxed by the latched ch_sel.

Behaviour:
- Reset: csn=all 1, sck=0, mosi=0, ce=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, done=0, err=0; FSM to IDLE. Reset mid-transaction takes effect on the next edge; no done pulse is issued.
- IDLE:
  - start with len==0, len>MAX_LEN, or ch_sel>=NUM_CH: pulse done+err next cycle; csn untouched; stay IDLE.
  - Otherwise latch ch_sel and len; busy=1; csn[ch]=0; go to SETUP.
- SETUP: wait CLK_DIV cycles (CSN setup), then go to LOAD.
- LOAD: tx_ready=1 for one cycle; latch tx_data into the shift register; mosi=bit7; go to SHIFT.
- SHIFT: 8 bits, MSB first, mode 0.
  - Each bit is a low half then a high half, CLK_DIV cycles each.
  - On the sck rising edge, sample miso[ch] into the shift-register LSB.
  - On the falling edge, shift and drive the next bit on mosi.
  - After bit 0's high half, sck returns low; go to NEXT.
  - Byte time = 16*CLK_DIV cycles.
- NEXT: rx_data=received byte; rx_valid=1 for one cycle; decrement remaining count. If nonzero go to LOAD (no extra gap), else go to HOLD.
- HOLD: wait CLK_DIV cycles with sck low, then csn[ch]=1, mosi=0; go to DONE.
- DONE: done=1 and busy=0 in the same cycle; return to IDLE. The earliest new start is accepted in the following cycle.
- start while busy is ignored, with no queuing. ch_sel, len and tx_data changes mid-transaction have no effect except tx_data at tx_ready.
- Only the selected csn ever goes low; never two at once. ce is independent of the FSM.

Optional Feature:
- Macro NRF_SPI_STATUS_CAPTURE_EN.
- Defined:
  - Adds output status[7:0], reset 0. It is loaded with the first byte received in each transaction (nRF24 STATUS), in the same cycle as that rx_valid.
  - Adds output status_valid, a 1-cycle pulse in that cycle.
  - status holds its value until the next transaction's first byte.
- Undefined: both ports are absent; behaviour is otherwise identical.

Test Plan:
- CLK_DIV=2, start, ch_sel=0, len=1, tx_data=0xA5, miso[0] replays 0x3C -> csn[0] low for exactly 1 + 2 + 32 + 1 + 2 cycles; mosi shows 1010_0101 MSB first; one rx_valid with rx_data=0x3C; one done; csn[1] stays 1.
- ch_sel=1, len=33, tx_data stream 0x20,0x00..0x1F; check tx_ready pulse spacing -> 33 tx_ready pulses spaced 33 cycles apart; 33 rx_valid; sck shows 264 rising edges; csn[1] low throughout.
- Request len=0, then len=40, then ch_sel=2 with NUM_CH=2 -> each gives done+err 1 cycle later; csn stays all 1; busy stays 0.
- start reasserted while busy, midway through byte 2 of len=3 -> ignored; exactly 3 bytes transferred and a single done.
- rst asserted during SHIFT of byte 1 -> next cycle csn=all 1, sck=0, busy=0, no done pulse; a fresh transaction then completes normally.
- With NRF_SPI_STATUS_CAPTURE_EN, len=2, miso replays 0x0E,0x55 -> status=0x0E with status_valid on the first rx_valid; status still 0x0E after done.
